rand_arbiter: RTL and testbench

Round-robin scheduler that shares one `rand_gen` instance among N requesters. It steps the generator with single-cycle `en` pulses and range-checks each 5-bit draw against the winning requester's limit. It retries rejected draws up to a bounded count, then returns the result to that requester with a one-cycle grant/valid pulse. It sits between game-logic clients and the single `rand_gen` datapath.

---
 rtl/rand_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rand_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rand_arbiter.sv
// Round-robin scheduler that shares one rand_gen among N requesters, range-checking
// each draw against the winner's limit with bounded retries before responding.
module rand_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 5,
  parameter int unsigned GEN_LAT = 1,
  parameter int unsigned MAX_TRY = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_lim,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_fail,
  output logic           busy,
  output logic           gen_en,
  input  logic [W-1:0]   gen_rnd
);

  localparam int unsigned ID_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW     = ID_W + 1;
  localparam int unsigned TRY_W  = $clog2(MAX_TRY + 1);
  localparam int unsigned WAIT_W = (GEN_LAT > 1) ? $clog2(GEN_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_next;
  logic [ID_W-1:0]   win_q;
  logic [W-1:0]      lim_q;
  logic [TRY_W-1:0]  tries_q;
  logic [WAIT_W-1:0] wait_q;

  logic [CW-1:0]     pick;
  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [W-1:0]      pick_lim;
  logic              accept;
  logic              retry;

  logic [N-1:0]      gnt_d;
  logic              rsp_valid_d;
  logic [W-1:0]      rsp_data_d;
  logic              rsp_fail_d;
  logic              busy_d;
  logic              gen_en_d;

  // First requester at or after p, ascending with wrap; MSB flags a hit.
  function automatic logic [CW-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
    logic [CW-1:0]   res;
    logic [CW-1:0]   sum;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = CW'(p) + CW'(i);
      if (sum >= CW'(N)) sum = sum - CW'(N);
      idx = sum[ID_W-1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick     = rr_pick(req, ptr_q);
  assign pick_vld = pick[ID_W];
  assign pick_id  = pick[ID_W-1:0];
  assign accept   = (gen_rnd <= lim_q);
  assign retry    = (tries_q < TRY_W'(MAX_TRY));
  assign ptr_next = (win_q == ID_W'(N - 1)) ? '0 : win_q + ID_W'(1);

  always_comb begin
    pick_lim = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_id == ID_W'(i)) pick_lim = req_lim[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_STEP;
      S_STEP:  state_d = (GEN_LAT > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (wait_q == WAIT_W'(GEN_LAT - 1)) state_d = S_CHECK;
      S_CHECK: state_d = (accept || !retry) ? S_DONE : S_STEP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_fail_d  = 1'b0;
    rsp_data_d  = rsp_data;
    busy_d      = (state_d != S_IDLE);
    gen_en_d    = (state_d == S_STEP);
    if (state_d == S_DONE) begin
      gnt_d       = N'(1) << win_q;
      rsp_valid_d = 1'b1;
      rsp_fail_d  = !accept;
      rsp_data_d  = accept ? gen_rnd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      lim_q   <= '0;
      tries_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            win_q   <= pick_id;
            lim_q   <= pick_lim;
            tries_q <= TRY_W'(1);
          end
        end
        S_STEP:  wait_q <= WAIT_W'(1);
        S_WAIT:  wait_q <= wait_q + WAIT_W'(1);
        S_CHECK: if (!accept && retry) tries_q <= tries_q + TRY_W'(1);
        S_DONE:  ptr_q <= ptr_next;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_fail  <= 1'b0;
      busy      <= 1'b0;
      gen_en    <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_fail  <= rsp_fail_d;
      busy      <= busy_d;
      gen_en    <= gen_en_d;
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: a queue-fed rand_gen stand-in plus a transaction-level
// model that predicts winner, outcome and per-cycle timing of each grant.
module tb_rand_arbiter;

  localparam int N       = 4;
  localparam int W       = 5;
  localparam int GEN_LAT = 1;
  localparam int MAX_TRY = 4;
  localparam int LMAX    = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_lim;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_fail;
  logic           busy;
  logic           gen_en;
  logic [W-1:0]   gen_rnd = '0;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_data = 0;
  int draw_q[$];

  rand_arbiter #(.N(N), .W(W), .GEN_LAT(GEN_LAT), .MAX_TRY(MAX_TRY)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lim(req_lim), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fail(rsp_fail),
    .busy(busy), .gen_en(gen_en), .gen_rnd(gen_rnd)
  );

  always #5 clk = ~clk;

  // rand_gen stand-in: each step presents the next queued draw one cycle later.
  always @(posedge clk) begin
    if (gen_en) begin
      if (draw_q.size() > 0) gen_rnd <= W'(draw_q.pop_front());
      else                   gen_rnd <= W'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the following IDLE cycle.
  task automatic run_txn(input int gap, input logic [N-1:0] r, input int lims[N], input int draws[MAX_TRY]);
    int win, lim, k_acc, ntry, done, exp_data, idx;
    logic [N-1:0] exp_gnt;
    logic exp_en;
    for (int g = 0; g < gap; g++) begin
      req = '0;
      @(negedge clk);
      chk("gap busy", 32'(busy), 0);
      chk("gap gnt", 32'(gnt), 0);
      tick();
    end

    win = -1;
    for (int o = 0; o < N; o++) begin
      idx = (m_ptr + o) % N;
      if (win < 0 && r[idx]) win = idx;
    end
    lim = lims[win];
    k_acc = 0;
    for (int k = 1; k <= MAX_TRY; k++)
      if (k_acc == 0 && draws[k-1] <= lim) k_acc = k;
    ntry     = (k_acc != 0) ? k_acc : MAX_TRY;
    done     = (k_acc != 0) ? (GEN_LAT + 2) + (k_acc - 1) * (GEN_LAT + 1)
                            : MAX_TRY * (GEN_LAT + 1) + 1;
    exp_data = (k_acc != 0) ? draws[k_acc-1] : 0;
    exp_gnt  = '0;
    exp_gnt[win] = 1'b1;

    for (int i = 0; i < N; i++) req_lim[i*W +: W] = W'(lims[i]);
    draw_q.delete();
    for (int i = 0; i < MAX_TRY; i++) draw_q.push_back(draws[i]);
    req = r;
    @(negedge clk);
    chk("c0 busy", 32'(busy), 0);
    chk("c0 gen_en", 32'(gen_en), 0);

    for (int c = 1; c <= done; c++) begin
      tick();
      if (c == 1) begin
        req = '0;
        req_lim = (N*W)'($urandom);
      end
      @(negedge clk);
      exp_en = ((c - 1) % (GEN_LAT + 1) == 0) && ((c - 1) / (GEN_LAT + 1) < ntry);
      chk($sformatf("gen_en c%0d", c), 32'(gen_en), 32'(exp_en));
      chk($sformatf("busy c%0d", c), 32'(busy), 1);
      chk($sformatf("rsp_valid c%0d", c), 32'(rsp_valid), 32'(c == done));
      chk($sformatf("gnt c%0d", c), 32'(gnt), (c == done) ? 32'(exp_gnt) : 0);
      chk($sformatf("rsp_fail c%0d", c), 32'(rsp_fail), (c == done) ? 32'(k_acc == 0) : 0);
      chk($sformatf("rsp_data c%0d", c), 32'(rsp_data), (c == done) ? exp_data : m_data);
    end
    m_data = exp_data;
    m_ptr  = (win + 1) % N;
    tick();
  endtask

  int lims[N];
  int draws[MAX_TRY];
  logic [N-1:0] rr;

  initial begin
    rst = 1'b1;
    req = '1;
    req_lim = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst gnt", 32'(gnt), 0);
      chk("rst rsp_valid", 32'(rsp_valid), 0);
      chk("rst rsp_data", 32'(rsp_data), 0);
      chk("rst rsp_fail", 32'(rsp_fail), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst gen_en", 32'(gen_en), 0);
    end
    tick();
    rst = 1'b0;

    // Requests re-raised every IDLE: back-to-back round-robin 0,1,2,3,0.
    for (int t = 0; t < 5; t++)
      run_txn(0, 4'b1111, '{LMAX, LMAX, LMAX, LMAX}, '{$urandom_range(0, LMAX), 0, 0, 0});

    run_txn(1, 4'b0001, '{LMAX, LMAX, LMAX, LMAX}, '{13, 0, 0, 0});
    run_txn(1, 4'b0100, '{LMAX, LMAX, 3, LMAX}, '{20, 17, 2, 0});
    run_txn(1, 4'b1000, '{LMAX, LMAX, LMAX, 0}, '{9, 9, 9, 9});
    run_txn(0, 4'b1001, '{0, LMAX, LMAX, LMAX}, '{0, 5, 5, 5});
    run_txn(2, 4'b0010, '{0, LMAX, 0, 0}, '{LMAX, 0, 0, 0});

    for (int t = 0; t < 300; t++) begin
      rr = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       lims[i] = 0;
          1:       lims[i] = LMAX;
          default: lims[i] = $urandom_range(0, LMAX);
        endcase
      end
      for (int i = 0; i < MAX_TRY; i++) draws[i] = $urandom_range(0, LMAX);
      run_txn($urandom_range(0, 2), rr, lims, draws);
    end

    // Reset asserted during the first CHECK aborts the grant.
    req = 4'b0100;
    req_lim = '1;
    draw_q.delete();
    draw_q.push_back(5);
    @(negedge clk);
    tick();
    req = '0;
    @(negedge clk);
    chk("abort step gen_en", 32'(gen_en), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort check busy", 32'(busy), 1);
    tick();
    rst = 1'b0;
    m_ptr = 0;
    m_data = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort busy", 32'(busy), 0);
      chk("abort gnt", 32'(gnt), 0);
      chk("abort rsp_valid", 32'(rsp_valid), 0);
      chk("abort rsp_fail", 32'(rsp_fail), 0);
      chk("abort rsp_data", 32'(rsp_data), 0);
      chk("abort gen_en", 32'(gen_en), 0);
      tick();
    end
    run_txn(0, 4'b1111, '{LMAX, LMAX, LMAX, LMAX}, '{7, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
